// File: rtl/sha1_arb_pkg.sv
// Shared types and widths for the SHA-1 request arbiter and its ID FIFO.
package sha1_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int SHA1_DATA_W   = 512;
  localparam int SHA1_KEEP_W   = 64;
  localparam int SHA1_DIGEST_W = 160;

endpackage

// File: rtl/sha1_id_fifo.sv
// In-order FIFO of requester IDs. One entry per granted message; the head
// is the ID of the oldest message whose digest has not yet been returned.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sha1_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Advance the read/write pointers; reset flushes every stored ID.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sha1_rr_arbiter.sv
// Shares one SHA-1 core between N_REQ AXI-Stream sources. Whole messages are
// granted round-robin and the grant is held until the tlast handshake. Each
// grant's ID is queued so that the in-order digests come back tagged.
module sha1_rr_arbiter
  import sha1_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ID_W       = $clog2(N_REQ),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [N_REQ-1:0]                      i_req_tvalid,
  input  logic [N_REQ-1:0][SHA1_DATA_W-1:0]     i_req_tdata,
  input  logic [N_REQ-1:0][SHA1_KEEP_W-1:0]     i_req_tkeep,
  input  logic [N_REQ-1:0]                      i_req_tlast,
  output logic [N_REQ-1:0]                      o_req_tready,
  output logic                                  o_core_tvalid,
  output logic [SHA1_DATA_W-1:0]                o_core_tdata,
  output logic [SHA1_KEEP_W-1:0]                o_core_tkeep,
  output logic                                  o_core_tlast,
  input  logic                                  i_core_tready,
  input  logic                                  i_core_sha_tvalid,
  input  logic [SHA1_DIGEST_W-1:0]              i_core_sha_tdata,
  output logic                                  o_core_sha_tready,
  output logic                                  o_res_tvalid,
  output logic [SHA1_DIGEST_W-1:0]              o_res_tdata,
  output logic [ID_W-1:0]                       o_res_tid,
  input  logic                                  i_res_tready,
  output logic                                  o_err_orphan
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  arb_state_t       state;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_sel;
  logic [ID_W-1:0]  rr_next;
  logic             grant_ok;
  logic             last_hs;

  logic             fifo_push;
  logic             fifo_pop;
  logic [ID_W-1:0]  fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // First valid requester at or above start, wrapping past N_REQ-1. Scanning
  // offsets from high to low lets the smallest offset win.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  start);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx_v;
    int              idx;
    pick = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx   = (int'(start) + k) % N_REQ;
      idx_v = ID_W'(idx);
      if (valid[idx_v]) pick = idx_v;
    end
    return pick;
  endfunction

  assign rr_sel   = rr_pick(i_req_tvalid, rr_ptr);
  assign rr_next  = (rr_sel == LAST_ID) ? '0 : rr_sel + 1'b1;
  assign grant_ok = (state == IDLE) && (|i_req_tvalid) && !fifo_full;
  assign last_hs  = (state == BURST) && i_req_tvalid[grant_id] &&
                    i_core_tready && i_req_tlast[grant_id];

  assign fifo_push = grant_ok;

  // Grant FSM: pick a requester in IDLE, hold it through the tlast beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            grant_id <= rr_sel;
            rr_ptr   <= rr_next;
            state    <= BURST;
          end
        end
        BURST: begin
          if (last_hs) state <= IDLE;
        end
      endcase
    end
  end

  // Mux the granted stream onto the core; nothing passes outside BURST.
  always_comb begin
    o_req_tready  = '0;
    o_core_tvalid = 1'b0;
    o_core_tdata  = i_req_tdata[grant_id];
    o_core_tkeep  = i_req_tkeep[grant_id];
    o_core_tlast  = i_req_tlast[grant_id];
    if (state == BURST) begin
      o_core_tvalid          = i_req_tvalid[grant_id];
      o_req_tready[grant_id] = i_core_tready;
    end
  end

  // Result path is purely combinational; digests with no pending ID are
  // swallowed so a misbehaving core cannot stall the output.
  assign o_res_tvalid      = i_core_sha_tvalid & ~fifo_empty;
  assign o_res_tdata       = i_core_sha_tdata;
  assign o_res_tid         = fifo_head;
  assign o_core_sha_tready = i_res_tready | fifo_empty;
  assign fifo_pop          = o_res_tvalid & i_res_tready;

  // Sticky orphan flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_err_orphan <= 1'b0;
    end else if (i_core_sha_tvalid && fifo_empty) begin
      o_err_orphan <= 1'b1;
    end
  end

  sha1_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (rr_sel),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
                                   $onehot0(o_req_tready));
  a_count_range:  assert property (@(posedge clk) disable iff (!reset_n)
                                   fifo_count <= DEPTH_CNT);
  a_full_count:   assert property (@(posedge clk) disable iff (!reset_n)
                                   fifo_full == (fifo_count == DEPTH_CNT));

endmodule
